// File: rtl/out_serializer_argmax.sv
// out_serializer_argmax
// Output stage behind the last conv/max-pool layer. Pooled 8-lane feature
// vectors are buffered, then serialized one lane per word onto a show-ahead
// output FIFO interface. After the last pixel of each image, one trailer
// word is appended. The trailer holds the index of the lane with the
// largest running maximum.
//
// Ports
//   clock           rising-edge clock
//   resetn          asynchronous, active-low reset
//   in_valid        in_data_0..7 carry one pixel vector
//   in_data_0..7    lane 0..7 feature values (IEEE-754 single, post-ReLU)
//   in_full         buffer full; in_valid is ignored while high
//   fifo_out_data   {image_class, data}; valid while !fifo_out_empty
//   fifo_out_rdreq  consumes the current word when !fifo_out_empty
//   fifo_out_empty  no word held on fifo_out_data
//   done            one-cycle pulse after a trailer word is consumed
module out_serializer_argmax #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 7,
  parameter int HEIGHT     = 7,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  input  logic [DATA_WIDTH-1:0] in_data_3,
  input  logic [DATA_WIDTH-1:0] in_data_4,
  input  logic [DATA_WIDTH-1:0] in_data_5,
  input  logic [DATA_WIDTH-1:0] in_data_6,
  input  logic [DATA_WIDTH-1:0] in_data_7,
  output logic                  in_full,
  output logic [DATA_WIDTH:0]   fifo_out_data,
  input  logic                  fifo_out_rdreq,
  output logic                  fifo_out_empty,
  output logic                  done
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int LAST   = PIXELS - 1;
  localparam int VEC_W  = 8 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, EMIT, TRAILER} state_t;

  state_t                state, state_next;
  logic [VEC_W-1:0]      mem [DEPTH];
  logic [VEC_W-1:0]      in_vec, head_vec, lane_vec;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic [DATA_WIDTH-1:0] max_q [8];
  logic [DATA_WIDTH-1:0] best;
  logic [PIX_W-1:0]      pix_cnt;
  logic [2:0]            lane;
  logic [2:0]            argmax;
  logic                  out_valid;
  logic                  wr_en, pop, load_lane, load_trailer, trailer_done, pix_inc;
  logic                  can_load, consume, buf_empty;

  // Negative features count as zero; non-negative IEEE-754 orders like unsigned.
  function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction

  assign in_vec         = {in_data_7, in_data_6, in_data_5, in_data_4,
                           in_data_3, in_data_2, in_data_1, in_data_0};
  assign head_vec       = mem[rd_ptr];
  assign wr_en          = in_valid && !in_full;
  assign buf_empty      = (count == '0);
  assign count_next     = count + CNT_W'(wr_en) - CNT_W'(pop);
  assign fifo_out_empty = !out_valid;
  assign consume        = out_valid && fifo_out_rdreq;
  assign can_load       = !out_valid || fifo_out_rdreq;

  // Vector storage; contents need no reset because the pointers gate all reads.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= in_vec;
  end

  // Buffer pointers and occupancy. in_full is registered from the next
  // occupancy, so a pop on a full buffer only frees the slot one cycle later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      in_full <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      in_full <= (count_next == CNT_W'(DEPTH));
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and datapath strobes. While emitting, the head vector is
  // popped on the same edge as lane 7 loads, so back-to-back vectors stream
  // without a bubble.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    load_lane    = 1'b0;
    load_trailer = 1'b0;
    trailer_done = 1'b0;
    pix_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!buf_empty) begin
          pop        = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (can_load) begin
          load_lane = 1'b1;
          if (lane == 3'd7) begin
            if (pix_cnt == PIX_W'(LAST)) begin
              state_next = TRAILER;
            end else begin
              pix_inc = 1'b1;
              if (!buf_empty) pop = 1'b1;
              else            state_next = IDLE;
            end
          end
        end
      end
      TRAILER: begin
        if (consume && fifo_out_data[DATA_WIDTH]) begin
          trailer_done = 1'b1;
          state_next   = IDLE;
        end else if (can_load) begin
          load_trailer = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Argmax over the running maxima. The strict compare keeps the lowest
  // index on ties, and an all-zero image yields lane 0.
  always_comb begin
    best   = '0;
    argmax = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (max_q[i] > best) begin
        best   = max_q[i];
        argmax = 3'(i);
      end
    end
  end

  // Lane register, running maxima, pixel counter and the output word register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lane_vec      <= '0;
      lane          <= 3'd0;
      pix_cnt       <= '0;
      out_valid     <= 1'b0;
      fifo_out_data <= '0;
      done          <= 1'b0;
      for (int i = 0; i < 8; i++) max_q[i] <= '0;
    end else begin
      if (pop) begin
        lane_vec <= head_vec;
        lane     <= 3'd0;
      end else if (load_lane) begin
        lane <= lane + 3'd1;
      end

      for (int i = 0; i < 8; i++) begin
        if (trailer_done)
          max_q[i] <= '0;
        else if (pop && (clamp(head_vec[i*DATA_WIDTH +: DATA_WIDTH]) > max_q[i]))
          max_q[i] <= clamp(head_vec[i*DATA_WIDTH +: DATA_WIDTH]);
      end

      if (trailer_done) pix_cnt <= '0;
      else if (pix_inc) pix_cnt <= pix_cnt + 1'b1;

      if (load_lane) begin
        out_valid     <= 1'b1;
        fifo_out_data <= {1'b0, lane_vec[lane*DATA_WIDTH +: DATA_WIDTH]};
      end else if (load_trailer) begin
        out_valid     <= 1'b1;
        fifo_out_data <= {1'b1, {(DATA_WIDTH-3){1'b0}}, argmax};
      end else if (consume) begin
        out_valid <= 1'b0;
      end

      done <= trailer_done;
    end
  end

endmodule
